traffic_light_sequencer: RTL

//  Consumer end of the 2-bit traffic-mode word from the mode register.

---
 rtl/traffic_light_if.sv | 11 +
 rtl/traffic_light_sequencer.sv | 114 +++++++++++
 2 files changed

// File: rtl/traffic_light_if.sv
// traffic_light_if: mode word in, lamp drive and pedestrian status out
interface traffic_light_if;
  logic [1:0] trafficMode;
  logic [2:0] nsLight;
  logic [2:0] ewLight;
  logic       pedWalk;
  logic       pedPending;
  logic [3:0] phase;
  modport master (output trafficMode, input nsLight, ewLight, pedWalk, pedPending, phase);
  modport slave  (input trafficMode, output nsLight, ewLight, pedWalk, pedPending, phase);
endinterface

// File: rtl/traffic_light_sequencer.sv
// traffic_light_sequencer: timed NS/EW lamp sequencing with pedestrian, night-flash and emergency preemption
module traffic_light_sequencer #(
  parameter int unsigned GREEN_CYCLES  = 20,
  parameter int unsigned YELLOW_CYCLES = 4,
  parameter int unsigned ALLRED_CYCLES = 2,
  parameter int unsigned WALK_CYCLES   = 10,
  parameter int unsigned CLEAR_CYCLES  = 6,
  parameter int unsigned FLASH_HALF    = 2,
  parameter int unsigned CNT_W         = 8
) (
  input logic clk,
  input logic rst,
  traffic_light_if.slave bus
);
  typedef enum logic [3:0] {
    ALL_RED   = 4'd0,
    NS_G      = 4'd1,
    NS_Y      = 4'd2,
    EW_G      = 4'd3,
    EW_Y      = 4'd4,
    PED_WALK  = 4'd5,
    PED_CLEAR = 4'd6,
    NIGHT     = 4'd7,
    EMG       = 4'd8
  } state_t;
  localparam logic [CNT_W-1:0] G_LD  = CNT_W'(GREEN_CYCLES - 1);
  localparam logic [CNT_W-1:0] Y_LD  = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] AR_LD = CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [CNT_W-1:0] W_LD  = CNT_W'(WALK_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_LD  = CNT_W'(CLEAR_CYCLES - 1);
  localparam logic [CNT_W-1:0] F_LD  = CNT_W'(FLASH_HALF - 1);
  state_t           state, state_nx;
  logic [CNT_W-1:0] timer, flash_cnt, load;
  logic             next_dir, next_dir_nx, ped_pending, flash;
  logic [1:0]       prev_mode;
  logic             done, emg, night, ped_rise, entry, flashing;
  logic [2:0]       ns, ew;
  logic             walk;
  assign done     = timer == '0;
  assign emg      = bus.trafficMode == 2'b11;
  assign night    = bus.trafficMode == 2'b01;
  assign ped_rise = bus.trafficMode == 2'b10 && prev_mode != 2'b10;
  assign entry    = state_nx != state;
  assign flashing = state_nx == NIGHT || state_nx == PED_CLEAR;
  // next_dir: 0 selects NS green next, 1 selects EW green next
  always_comb begin
    state_nx    = state;
    next_dir_nx = next_dir;
    case (state)
      NS_G:      if (emg || done) state_nx = NS_Y;
      NS_Y:      if (done) begin state_nx = ALL_RED; next_dir_nx = 1'b1; end
      EW_G:      if (emg || done) state_nx = EW_Y;
      EW_Y:      if (done) begin state_nx = ALL_RED; next_dir_nx = 1'b0; end
      ALL_RED:   if (emg) state_nx = EMG;
                 else if (done) state_nx = ped_pending ? PED_WALK : night ? NIGHT : next_dir ? EW_G : NS_G;
      PED_WALK:  if (emg) state_nx = EMG; else if (done) state_nx = PED_CLEAR;
      PED_CLEAR: if (emg) state_nx = EMG; else if (done) state_nx = next_dir ? EW_G : NS_G;
      NIGHT:     if (emg) state_nx = EMG;
                 else if (!night) begin state_nx = ALL_RED; next_dir_nx = 1'b0; end
      EMG:       if (!emg) begin state_nx = ALL_RED; next_dir_nx = 1'b0; end
      default:   state_nx = ALL_RED;
    endcase
  end
  always_comb begin
    load = '0;
    case (state_nx)
      NS_G, EW_G: load = G_LD;
      NS_Y, EW_Y: load = Y_LD;
      ALL_RED:    load = AR_LD;
      PED_WALK:   load = W_LD;
      PED_CLEAR:  load = C_LD;
      default:    load = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ALL_RED;
      timer       <= AR_LD;
      next_dir    <= 1'b0;
      ped_pending <= 1'b0;
      flash       <= 1'b1;
      flash_cnt   <= F_LD;
      prev_mode   <= 2'b00;
    end else begin
      state       <= state_nx;
      next_dir    <= next_dir_nx;
      prev_mode   <= bus.trafficMode;
      timer       <= entry ? load : done ? timer : timer - 1'b1;
      ped_pending <= (entry && state_nx == PED_WALK) ? 1'b0 : ped_rise ? 1'b1 : ped_pending;
      flash       <= (!flashing || entry) ? 1'b1 : flash_cnt == '0 ? ~flash : flash;
      flash_cnt   <= (!flashing || entry || flash_cnt == '0) ? F_LD : flash_cnt - 1'b1;
    end
  end
  always_comb begin
    ns   = 3'b100;
    ew   = 3'b100;
    walk = 1'b0;
    case (state)
      NS_G:      ns = 3'b001;
      NS_Y:      ns = 3'b010;
      EW_G:      ew = 3'b001;
      EW_Y:      ew = 3'b010;
      PED_WALK:  walk = 1'b1;
      PED_CLEAR: walk = flash;
      NIGHT:     begin ns = {1'b0, flash, 1'b0}; ew = {flash, 2'b00}; end
      default:   ;
    endcase
  end
  assign bus.nsLight    = ns;
  assign bus.ewLight    = ew;
  assign bus.pedWalk    = walk;
  assign bus.pedPending = ped_pending;
  assign bus.phase      = state;
endmodule
